// File: rtl/aes128_iter_enc.sv
// Iterative AES-128 encryption engine: ROUNDS_PER_CYCLE rounds per clock, on-the-fly key expansion.
// Byte k of every 128-bit bus is bits [8k:8k+7]; state bytes are column-major (byte k = row k%4, col k/4).
module aes128_iter_enc #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);
  localparam int NCYC = 10 / ROUNDS_PER_CYCLE;

  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 &&
      ROUNDS_PER_CYCLE != 5 && ROUNDS_PER_CYCLE != 10) begin : g_bad_rpc
    $error("aes128_iter_enc: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef logic [0:127] blk_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // S-box table shared by SubBytes and SubWord; entry b sits at bits [8b:8b+7].
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: out[r][c] = S(in[r][(c+r)%4]).
  function automatic blk_t sub_shift(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = sbox(s[8*(r+4*((c+r)%4)) +: 8]);
    return o;
  endfunction

  function automatic blk_t mix_columns(input blk_t s);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c +: 8]    = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[32*c+8 +: 8]  = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[32*c+24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic blk_t next_key(input blk_t k, input logic [7:0] rc);
    blk_t o;
    logic [31:0] t;
    t = {sbox(k[104 +: 8]) ^ rc, sbox(k[112 +: 8]), sbox(k[120 +: 8]), sbox(k[96 +: 8])};
    o[0 +: 32]  = k[0 +: 32] ^ t;
    o[32 +: 32] = k[32 +: 32] ^ o[0 +: 32];
    o[64 +: 32] = k[64 +: 32] ^ o[32 +: 32];
    o[96 +: 32] = k[96 +: 32] ^ o[64 +: 32];
    return o;
  endfunction

  fsm_e       fsm_q, fsm_d;
  blk_t       state_q, rk_q, state_d, rk_d;
  logic [7:0] rcon_q, rcon_d;
  logic [3:0] cnt_q;
  logic       last_cycle;

  assign last_cycle = (fsm_q == RUN) && (cnt_q == 4'(NCYC - 1));

  // NOTE: blocking assignments here chain the unrolled rounds within one cycle;
  // each accumulator is seeded before use so no latch is inferred.
  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    rcon_d  = rcon_q;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      rk_d    = next_key(rk_d, rcon_d);
      rcon_d  = xtime(rcon_d);
      state_d = sub_shift(state_d);
      if (int'(cnt_q) * ROUNDS_PER_CYCLE + r != 9)
        state_d = mix_columns(state_d);
      state_d = state_d ^ rk_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) fsm_d = RUN;
      end
      RUN:  if (last_cycle) fsm_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= '0;
      rk_q     <= '0;
      rcon_q   <= '0;
      cnt_q    <= '0;
      out_data <= '0;
    end else if (fsm_q == IDLE && in_valid) begin
      state_q <= in_data ^ in_key;
      rk_q    <= in_key;
      rcon_q  <= 8'h01;
      cnt_q   <= '0;
    end else if (fsm_q == RUN) begin
      state_q <= state_d;
      rk_q    <= rk_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_q + 4'd1;
      if (last_cycle) out_data <= state_d;
    end
  end

endmodule

// File: doc/aes128_iter_enc.md
Name: aes128_iter_enc

Overview:
- Iterative, clocked AES-128 encryption engine. Successor to the current combinational single-block `top` datapath.
- Accepts one 128-bit plaintext and 128-bit key through a valid/ready handshake.
- Performs the 10 FIPS-197 rounds with on-the-fly key expansion, unrolled by a parameter. Returns the ciphertext through a valid/ready handshake.
- Sits between the message source and any downstream consumer. Reuses the existing sbox block for SubBytes and SubWord.

Parameters:
- ROUNDS_PER_CYCLE, default 1. Rounds computed per clock. Legal values are 1, 2, 5 and 10; any other value is an elaboration error.
- NCYC, default 10/ROUNDS_PER_CYCLE. Derived localparam, not overridable. Number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  engine can accept
- in_data  in  [0:127]  plaintext; byte k = bits [8k:8k+7]; state column-major per FIPS-197
- in_key  in  [0:127]  cipher key; same byte ordering
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts
- out_data  out  [0:127]  ciphertext; same byte ordering
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release):
  - FSM goes to IDLE.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - State, round key and rcon registers are cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready: state_reg <= in_data XOR in_key (initial AddRoundKey), rk_reg <= in_key, rcon <= 8'h01, cnt <= 0, then go to RUN.
  - in_data and in_key are not sampled at any other time.
- RUN:
  - in_ready=0.
  - Each cycle applies ROUNDS_PER_CYCLE rounds combinationally.
  - Each round:
    - derive next round key from rk_reg: RotWord, SubWord, XOR rcon, then the word-XOR chain;
    - apply SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - rcon advances by xtime per round: 01,02,04,08,10,20,40,80,1b,36.
  - Global round 10 omits MixColumns.
  - cnt increments per cycle.
  - On the edge where cnt==NCYC-1: out_data <= final state, out_valid <= 1, go to DONE.
- DONE:
  - out_data and out_valid are held stable until out_valid&&out_ready.
  - On that edge: out_valid <= 0, go to IDLE. out_data keeps its last value.
  - in_ready=0 in DONE, so no overlap. A new block can be accepted on the cycle after the handoff.
- Latency: acceptance edge T0 → out_valid high after edge T0+NCYC (10, 5, 2 or 1 cycles).
- Throughput: one block per NCYC+2 cycles when out_ready is held high.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the block:
  - the in-flight result is discarded;
  - out_valid drops asynchronously;
  - no partial result is ever presented.
- All arithmetic is GF(2^8) with polynomial 0x11b. There is no carry or width growth; every datapath is 128 bits.
- out_valid must never be high in the same cycle as in_ready.

Test Plan:
1. FIPS-197 C.1 vector, ROUNDS_PER_CYCLE=1:
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
   - Required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after the accept edge.
2. FIPS-197 Appendix B vector, ROUNDS_PER_CYCLE in {2,5,10}:
   - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734.
   - Required: 3925841d02dc09fbdc118597196a0b32 at latency 5, 2 and 1 respectively.
3. Backpressure:
   - Stimulus: out_ready=0 for 7 cycles after out_valid rises.
   - Required: out_data and out_valid stable and in_ready=0 throughout; handoff on the first out_ready=1 edge; in_ready=1 the next cycle.
4. Back-to-back blocks:
   - Stimulus: in_valid held high with vector 1 then vector 2, out_ready=1.
   - Required: both ciphertexts correct and in order, one block per NCYC+2 cycles.
   - Required: in_data changes while busy are ignored (change pt during RUN; result unaffected).
5. Reset mid-RUN:
   - Stimulus: assert rst at cycle 4 of RUN, asynchronously between edges.
   - Required: out_valid=0, busy=0, in_ready=1 immediately; a fresh vector 1 after release yields 69c4e0d8… with normal latency.
6. Reset mid-DONE:
   - Stimulus: rst while out_valid=1 and out_ready=0.
   - Required: out_valid and out_data clear to 0 without a handshake; a subsequent block completes normally.
